// File: rtl/alu_pkg.sv
// alu_pkg: FSM states and ALU opcode set shared by the UART-driven ALU sequencer.
package alu_pkg;
    typedef enum logic [2:0] {GET_A, GET_B, GET_OP, EXEC, SEND, WAIT_TX} state_e;
    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    function automatic logic is_valid_op(input logic [5:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL};
    endfunction
endpackage

// File: rtl/alu_seq_timeout.sv
// alu_seq_timeout: inter-byte down-counter; expired_o flags a stall in GET_B/GET_OP.
module alu_seq_timeout #(
    parameter int CYCLES = 16
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic load_i,
    input  logic run_i,
    output logic expired_o
);
    localparam int W = $clog2(CYCLES + 1);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load_i ? W'(CYCLES - 1) : (run_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    always_ff @(posedge Clk) begin
        if (!Reset_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign expired_o = run_i && cnt_q == '0;
endmodule

// File: rtl/alu_uart_sequencer.sv
// alu_uart_sequencer: collects A, B, opcode bytes, drives the ALU and sends the result back.
// Optional inter-byte timeout enabled by defining ALU_SEQ_TIMEOUT_EN.
module alu_uart_sequencer import alu_pkg::*; #(
    parameter int N              = 7,
    parameter int OP_W           = 6,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic [N:0]      RxData,
    input  logic            RxDone,
    input  logic            TxDone,
    input  logic [N:0]      AluResult,
    output logic [N:0]      BusA,
    output logic [N:0]      BusB,
    output logic [OP_W-1:0] OpCode,
    output logic [N:0]      TxData,
    output logic            TxStart,
    output logic            Busy,
    output logic            OpErr
);
    state_e          state_q, state_d;
    logic [N:0]      bus_a_q, bus_a_d, bus_b_q, bus_b_d, tx_data_q, tx_data_d;
    logic [OP_W-1:0] op_q, op_d;
    logic            tx_start_q, tx_start_d, busy_q, busy_d, op_err_q, op_err_d;
    logic            tmo_expired;

`ifdef ALU_SEQ_TIMEOUT_EN
    alu_seq_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .load_i    (RxDone && state_q inside {GET_A, GET_B, GET_OP}),
        .run_i     (state_q inside {GET_B, GET_OP}),
        .expired_o (tmo_expired)
    );
`else
    assign tmo_expired = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_d    = state_q;
        bus_a_d    = bus_a_q;
        bus_b_d    = bus_b_q;
        op_d       = op_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        op_err_d   = 1'b0;
        case (state_q)
            GET_A: if (RxDone) begin
                bus_a_d = RxData;
                state_d = GET_B;
            end
            GET_B: if (RxDone) begin
                bus_b_d = RxData;
                state_d = GET_OP;
            end else if (tmo_expired) state_d = GET_A;
            GET_OP: if (RxDone) begin
                op_d     = RxData[OP_W-1:0];
                op_err_d = !is_valid_op(RxData[OP_W-1:0]);
                state_d  = EXEC;
            end else if (tmo_expired) state_d = GET_A;
            EXEC: begin
                tx_data_d  = AluResult;
                tx_start_d = 1'b1;
                state_d    = SEND;
            end
            SEND:    state_d = WAIT_TX;
            WAIT_TX: if (TxDone) state_d = GET_A;
            default: state_d = GET_A;
        endcase
        busy_d = state_d != GET_A;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q    <= GET_A;
            bus_a_q    <= '0;
            bus_b_q    <= '0;
            op_q       <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            op_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bus_a_q    <= bus_a_d;
            bus_b_q    <= bus_b_d;
            op_q       <= op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            op_err_q   <= op_err_d;
        end
    end

    assign BusA    = bus_a_q;
    assign BusB    = bus_b_q;
    assign OpCode  = op_q;
    assign TxData  = tx_data_q;
    assign TxStart = tx_start_q;
    assign Busy    = busy_q;
    assign OpErr   = op_err_q;
endmodule

// File: tb/tb_alu_uart_sequencer.sv
// tb_alu_uart_sequencer: directed and randomized byte sequences against an ALU behaviour model.
module tb_alu_uart_sequencer;
    localparam int TMO = 16;
    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic [7:0] RxData = '0;
    logic       RxDone = 1'b0;
    logic       TxDone = 1'b0;
    logic [7:0] AluResult;
    logic [7:0] BusA, BusB, TxData;
    logic [5:0] OpCode;
    logic       TxStart, Busy, OpErr;
    int         checks = 0;
    int         errors = 0;
    logic [5:0] ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};

    alu_uart_sequencer #(.N(7), .OP_W(6), .TIMEOUT_CYCLES(TMO)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .RxData(RxData), .RxDone(RxDone), .TxDone(TxDone),
        .AluResult(AluResult), .BusA(BusA), .BusB(BusB), .OpCode(OpCode), .TxData(TxData),
        .TxStart(TxStart), .Busy(Busy), .OpErr(OpErr)
    );

    always #5 Clk = ~Clk;

    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h03:   return {a[7], a[7:1]};
            6'h02:   return a >> 1;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic op_ok(input logic [5:0] op);
        for (int i = 0; i < 8; i++) if (ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    assign AluResult = alu_model(BusA, BusB, OpCode);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge Clk); #1;
        RxData = b;
        RxDone = 1'b1;
        @(posedge Clk); #1;
        RxDone = 1'b0;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busa"}, 32'(BusA), 0);
        check({tag, "_busb"}, 32'(BusB), 0);
        check({tag, "_op"}, 32'(OpCode), 0);
        check({tag, "_txd"}, 32'(TxData), 0);
        check({tag, "_ctl"}, {29'd0, TxStart, Busy, OpErr}, 0);
    endtask

    task automatic run_seq(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           input logic [7:0] exp_tx, input logic exp_err, input logic drop);
        send_byte(a);
        check("busy_after_a", 32'(Busy), 1);
        check("busa", 32'(BusA), 32'(a));
        repeat ($urandom_range(0, 2)) @(posedge Clk);
        send_byte(b);
        send_byte(op);
        check("operr_exec", 32'(OpErr), 32'(exp_err));
        check("txstart_exec", 32'(TxStart), 0);
        @(posedge Clk); #1;
        check("txstart_send", 32'(TxStart), 1);
        check("txdata", 32'(TxData), 32'(exp_tx));
        check("operr_send", 32'(OpErr), 0);
        @(posedge Clk); #1;
        check("txstart_wait", 32'(TxStart), 0);
        if (drop) send_byte(8'h77);
        check("hold_busa", 32'(BusA), 32'(a));
        check("hold_op", 32'(OpCode), 32'(op[5:0]));
        check("busy_wait", 32'(Busy), 1);
        repeat ($urandom_range(0, 3)) @(posedge Clk);
        #1 TxDone = 1'b1;
        @(posedge Clk); #1;
        TxDone = 1'b0;
        check("busy_done", 32'(Busy), 0);
    endtask

    initial begin
        logic [7:0] a, b, op;
        repeat (2) @(posedge Clk);
        #1 check_idle_zero("reset");
        Reset_n = 1'b1;
        run_seq(8'h05, 8'h03, 8'h20, 8'h08, 1'b0, 1'b0);
        run_seq(8'h03, 8'h05, 8'h22, 8'hFE, 1'b0, 1'b0);
        run_seq(8'h80, 8'h00, 8'h03, 8'hC0, 1'b0, 1'b0);
        run_seq(8'h80, 8'h00, 8'h02, 8'h40, 1'b0, 1'b0);
        run_seq(8'hAA, 8'h55, 8'h3F, 8'h00, 1'b1, 1'b0);
        run_seq(8'h10, 8'h20, 8'h25, 8'h30, 1'b0, 1'b1);
        run_seq(8'h01, 8'h01, 8'h20, 8'h02, 1'b0, 1'b0);
        send_byte(8'h12);
        send_byte(8'h34);
        @(posedge Clk); #1 Reset_n = 1'b0;
        @(posedge Clk); #1 Reset_n = 1'b1;
        check_idle_zero("midreset");
        run_seq(8'h0F, 8'hF0, 8'h25, 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            op = ($urandom_range(0, 1) == 1) ? {2'($urandom), ops[$urandom_range(0, 7)]} : 8'($urandom);
            run_seq(a, b, op, op_ok(op[5:0]) ? alu_model(a, b, op[5:0]) : 8'h00,
                    !op_ok(op[5:0]), 1'($urandom_range(0, 1)));
        end
`ifdef ALU_SEQ_TIMEOUT_EN
        send_byte(8'h21);
        repeat (TMO - 1) @(posedge Clk);
        #1 check("tmo_not_yet", 32'(Busy), 1);
        @(posedge Clk); #1;
        check("tmo_expired", 32'(Busy), 0);
        check("tmo_keep_a", 32'(BusA), 32'h21);
        send_byte(8'h44);
        repeat (TMO - 1) @(posedge Clk);
        #1 RxData = 8'h66;
        RxDone = 1'b1;
        @(posedge Clk); #1;
        RxDone = 1'b0;
        check("tmo_edge_busy", 32'(Busy), 1);
        check("tmo_edge_b", 32'(BusB), 32'h66);
        send_byte(8'h20);
        @(posedge Clk); #1;
        check("tmo_edge_tx", 32'(TxData), 32'hAA);
        @(posedge Clk); #1 TxDone = 1'b1;
        @(posedge Clk); #1 TxDone = 1'b0;
        check("tmo_edge_done", 32'(Busy), 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_uart_sequencer.md
Name: alu_uart_sequencer

Overview:
FSM that sequences the shared ALU from a byte-serial link (UART RX/TX cores).
It collects three bytes in order (operand A, operand B, opcode), then holds the ALU inputs stable and captures the result. The result goes back out through the TX core with a start/done handshake.
It is the only driver of the ALU's BusA, BusB and OpCode inputs.

Parameters:
N, 7, data MSB index; bus width N+1, matches the ALU and the UART byte width.
OP_W, 6, opcode width driven to the ALU.
TIMEOUT_CYCLES, 50000000, inter-byte timeout in Clk cycles; used only with the optional feature.

Ports:
Clk  in  1  system clock, rising edge.
Reset_n  in  1  synchronous, active-low reset.
RxData  in  N+1  byte from the UART RX core; valid when RxDone=1.
RxDone  in  1  one-cycle pulse: RxData is valid.
TxDone  in  1  one-cycle pulse: TX core finished the current byte.
AluResult  in  N+1  ALU Result output (combinational).
BusA  out  N+1  ALU operand A (registered).
BusB  out  N+1  ALU operand B (registered).
OpCode  out  OP_W  ALU opcode (registered).
TxData  out  N+1  byte handed to the TX core.
TxStart  out  1  one-cycle pulse: begin transmitting TxData.
Busy  out  1  high in every state other than GET_A.
OpErr  out  1  one-cycle pulse: received opcode is not a defined ALU opcode.

Behaviour:
- Reset: sampled only on a rising Clk edge with Reset_n=0. Effects:
  - State goes to GET_A.
  - BusA, BusB, OpCode, TxData are all set to 0.
  - TxStart, OpErr, Busy are all set to 0.
  - Reset wins over every other event. A reset mid-sequence discards the partial operands; a reset in WAIT_TX abandons the TX handshake.
- States: GET_A -> GET_B -> GET_OP -> EXEC -> SEND -> WAIT_TX -> GET_A.
- GET_A: on RxDone, BusA <= RxData and go to GET_B.
- GET_B: on RxDone, BusB <= RxData and go to GET_OP.
- GET_OP: on RxDone, OpCode <= RxData[OP_W-1:0] and go to EXEC. Upper RxData bits are ignored.
- EXEC: exactly one cycle, while the ALU inputs are stable.
  - TxData <= AluResult.
  - OpErr pulses if OpCode is not in the package's valid-opcode set.
  - Go to SEND.
- Undefined opcodes are still executed and transmitted. The ALU then yields 0, so TxData=0.
- SEND: TxStart=1 for exactly this cycle; go to WAIT_TX.
- WAIT_TX: hold until TxDone, then go to GET_A.
  - TxDone in any other state is ignored.
  - BusA, BusB, OpCode keep their values until overwritten by the next sequence.
- Latency: RxDone of the opcode byte at edge k gives TxStart high in the cycle after edge k+1 (two edges).
- RxDone pulses arriving in EXEC, SEND or WAIT_TX are dropped: no state change, no register update.
- Arithmetic: none inside this block. Widths pass through unchanged, and the ALU result is taken modulo 2^(N+1).
- All outputs are registered. There are no combinational paths from inputs to outputs.

Optional Feature:
Macro ALU_SEQ_TIMEOUT_EN.
- Defined:
  - A down-counter loads TIMEOUT_CYCLES-1 on entry to GET_B or GET_OP, and on every accepted byte.
  - It decrements each cycle while in GET_B or GET_OP.
  - When it reaches 0 without RxDone, the FSM returns to GET_A. BusA, BusB and OpCode are left as they are.
  - RxDone in the same cycle as expiry wins: the byte is accepted and there is no timeout.
- Undefined: no counter is synthesized, and the FSM waits indefinitely in GET_B and GET_OP.

Decomposition:
- Shared package alu_pkg:
  - State enum: GET_A, GET_B, GET_OP, EXEC, SEND, WAIT_TX.
  - Opcode constants: OP_ADD=6'b100000, OP_SUB=6'b100010, OP_AND=6'b100100, OP_OR=6'b100101, OP_XOR=6'b100110, OP_NOR=6'b100111, OP_SRA=6'b000011, OP_SRL=6'b000010.
  - An is_valid_op function.
- Natural sub-module: alu_seq_timeout (the timeout counter), instantiated only under ALU_SEQ_TIMEOUT_EN. The FSM stays in the top module.

Test Plan:
- Send 0x05, 0x03, 0x20; pulse TxDone after TxStart.
  -> TxData=0x08, one TxStart pulse, OpErr=0, Busy returns to 0.
- Send 0x03, 0x05, 0x22 -> TxData=0xFE.
- Send 0x80, 0x00, 0x03 -> TxData=0xC0.
- Send 0x80, 0x00, 0x02 -> TxData=0x40.
- Send 0xAA, 0x55, 0x3F -> OpErr pulses once in EXEC; TxData=0x00; TxStart still pulses.
- Pulse RxDone=0x77 during WAIT_TX, then finish with TxDone.
  -> Byte ignored; FSM in GET_A; next sequence 0x01, 0x01, 0x20 gives TxData=0x02.
- Drive Reset_n=0 for one cycle after the B byte.
  -> All outputs 0, state GET_A; a fresh 0x0F, 0xF0, 0x25 gives TxData=0xFF.
- With ALU_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16: send A, then stay idle for 16 cycles.
  -> Back in GET_A, Busy=0; RxDone exactly on the expiry cycle is accepted as B.
